inst_dispatcher: RTL
====================

Name: inst_dispatcher

Overview:
Instruction queue plus issue controller between the fetcher and the out-of-order backend (ROB, reservation station, load/store buffer). It buffers fetched instructions and decodes the queue head with the combinational Decoder. It dispatches at most one instruction per cycle to the ROB and to exactly one of RS or LSB, stalling on backend fullness. It flushes on rollback.

Parameters:
IQ_ADDR_W, 4, log2 of queue depth (16 entries)
ROB_TAG_W, 4, width of ROB entry tag

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
rdy  in  1  global enable; low = freeze all state, no dispatch
rollback  in  1  mispredict flush from ROB commit
fetch_valid  in  1  fetcher presents an instruction this cycle
fetch_inst  in  32  raw instruction word
fetch_pc  in  32  instruction PC
fetch_pred_jump  in  1  predictor said taken
iq_full  out  1  combinational, count==2^IQ_ADDR_W; fetcher must not push while high
rob_full  in  1  ROB cannot accept a dispatch this cycle
rob_free_tag  in  ROB_TAG_W  tag the ROB assigns to the next dispatch
rs_full  in  1  RS cannot accept
lsb_full  in  1  LSB cannot accept
disp_rob_valid  out  1  one-cycle pulse, allocate ROB entry
disp_rs_valid  out  1  one-cycle pulse, insert into RS
disp_lsb_valid  out  1  one-cycle pulse, insert into LSB
disp_op  out  6  decoded op id
disp_rd / disp_rs1 / disp_rs2  out  5 each  register indices
disp_imm  out  32  decoded immediate
disp_pc  out  32  PC of dispatched instruction
disp_pred_jump  out  1  prediction bit
disp_is_jump / disp_is_branch  out  1 each  decode flags
disp_tag  out  ROB_TAG_W  rob_free_tag sampled at dispatch

Behaviour:
- Reset (rst=1 on edge): head=tail=count=0, state=RUN, all disp_*_valid=0, all other disp_* outputs=0. Reset overrides rollback and rdy.
- rdy=0: no pointer, count, or state change; disp_*_valid cleared to 0 on that edge.
- Queue: circular, head/tail wrap modulo 2^IQ_ADDR_W. count is IQ_ADDR_W+1 bits. Push when fetch_valid && !iq_full && state==RUN. Entry = {inst, pc, pred_jump}.
- Dispatch condition (state RUN, count!=0, !rob_full): head decoded combinationally.
  - is_load|is_store: requires !lsb_full; sets disp_lsb_valid.
  - Any other non-NOP op (incl. LUI, AUIPC, JAL, JALR, branches): requires !rs_full; sets disp_rs_valid.
  - Decoded NOP (unknown opcode): ROB only, disp_op=NOP.
  - disp_rob_valid=1 with every dispatch.
  - Outputs registered on the edge; head++.
- Condition false: all valid outputs 0 next cycle; data outputs hold last values.
- Latency: instruction pushed on edge E is dispatched earliest on edge E+1 (outputs valid in the cycle after E+1). Push does not bypass into dispatch.
- Simultaneous push and pop: count unchanged. At count==full, push is blocked even if a pop occurs the same cycle (iq_full is count-based).
- Backend fullness: rob_full/rs_full/lsb_full must already account for a dispatch registered in the previous cycle. This block does not track credits.
- State machine RUN/FLUSH:
  - rollback=1 in RUN: next edge sets head=tail=count=0, clears all valids, state=FLUSH; same-cycle push and dispatch are discarded.
  - FLUSH: one cycle, no push/dispatch, iq_full=0; then RUN.
  - rollback in FLUSH re-enters FLUSH.
- Immediate/field formats come unchanged from the Decoder. Branch/store rd forced 0.

Decomposition:
- Shared defines file: op-id constants (NOP, LUI, ..., SRAI), opcode/funct constants, IQ_ADDR_W, ROB_TAG_W, state encodings RUN=1'b0, FLUSH=1'b1.
- Sub-modules: existing combinational Decoder instanced on head inst; queue storage kept inline (natural split if needed: iq_fifo).

Test Plan:
- Reset then push addi x1,x0,5 (0x00500093, pc 0x0) -> two edges later disp_rob_valid=1, disp_rs_valid=1, disp_lsb_valid=0, disp_op=ADDI, rd=1, rs1=0, imm=5, disp_pc=0.
- Push lw x2,4(x1) (0x0040A103) with lsb_full=1 for 3 cycles -> no valids while full; on release one pulse with disp_lsb_valid=1, rd=2, rs1=1, imm=4, disp_tag=rob_free_tag.
- Push 16 instructions with rob_full=1 -> iq_full=1 after 16th; 17th push ignored; release rob_full -> 16 dispatches in order, iq_full drops after first pop.
- Queue holding 5 entries, assert rollback with simultaneous fetch_valid -> next cycle count=0, valids 0, one FLUSH cycle ignoring fetch, then a new push dispatches normally.
- Hold rdy=0 for 4 cycles with fetch_valid=1 and count=2 -> count stays 2, no dispatch; rdy=1 resumes in order.
- Push 0xFFFFFFFF -> dispatched ROB-only, disp_op=NOP, disp_rs_valid=disp_lsb_valid=0.

Source files
------------

// File: rtl/inst_dispatcher_pkg.sv
// Shared constants for the instruction dispatcher: op ids, RV32I opcodes, sizes, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package inst_dispatcher_pkg;

    localparam int IQ_ADDR_W_DEF = 4;
    localparam int ROB_TAG_W_DEF = 4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // One queued instruction as it arrived from the fetcher
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred_jump;
    } iq_entry_t;

    // Decoded op ids (NOP doubles as "unknown / illegal")
    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_LUI   = 6'd1;
    localparam logic [5:0] OP_AUIPC = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_JALR  = 6'd4;
    localparam logic [5:0] OP_BEQ   = 6'd5;
    localparam logic [5:0] OP_BNE   = 6'd6;
    localparam logic [5:0] OP_BLT   = 6'd7;
    localparam logic [5:0] OP_BGE   = 6'd8;
    localparam logic [5:0] OP_BLTU  = 6'd9;
    localparam logic [5:0] OP_BGEU  = 6'd10;
    localparam logic [5:0] OP_LB    = 6'd11;
    localparam logic [5:0] OP_LH    = 6'd12;
    localparam logic [5:0] OP_LW    = 6'd13;
    localparam logic [5:0] OP_LBU   = 6'd14;
    localparam logic [5:0] OP_LHU   = 6'd15;
    localparam logic [5:0] OP_SB    = 6'd16;
    localparam logic [5:0] OP_SH    = 6'd17;
    localparam logic [5:0] OP_SW    = 6'd18;
    localparam logic [5:0] OP_ADD   = 6'd19;
    localparam logic [5:0] OP_SUB   = 6'd20;
    localparam logic [5:0] OP_SLL   = 6'd21;
    localparam logic [5:0] OP_SLT   = 6'd22;
    localparam logic [5:0] OP_SLTU  = 6'd23;
    localparam logic [5:0] OP_XOR   = 6'd24;
    localparam logic [5:0] OP_SRL   = 6'd25;
    localparam logic [5:0] OP_SRA   = 6'd26;
    localparam logic [5:0] OP_OR    = 6'd27;
    localparam logic [5:0] OP_AND   = 6'd28;
    localparam logic [5:0] OP_ADDI  = 6'd29;
    localparam logic [5:0] OP_SLTI  = 6'd30;
    localparam logic [5:0] OP_SLTIU = 6'd31;
    localparam logic [5:0] OP_XORI  = 6'd32;
    localparam logic [5:0] OP_ORI   = 6'd33;
    localparam logic [5:0] OP_ANDI  = 6'd34;
    localparam logic [5:0] OP_SLLI  = 6'd35;
    localparam logic [5:0] OP_SRLI  = 6'd36;
    localparam logic [5:0] OP_SRAI  = 6'd37;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/inst_dispatcher_decoder.sv
// Combinational RV32I decoder: op id, register fields, immediate, class flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; unknown encodings decode to OP_NOP with all fields zero.
// Ports: i_inst raw word; o_op/o_rd/o_rs1/o_rs2/o_imm decoded fields;
//        o_is_jump/o_is_branch/o_is_load/o_is_store class flags.
module inst_dispatcher_decoder
    import inst_dispatcher_pkg::*;
(
    input  logic [31:0] i_inst,
    output logic [5:0]  o_op,
    output logic [4:0]  o_rd,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [31:0] o_imm,
    output logic        o_is_jump,
    output logic        o_is_branch,
    output logic        o_is_load,
    output logic        o_is_store
);
    logic [6:0]  w_opc, w_f7;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

    assign w_opc   = i_inst[6:0];
    assign w_f3    = i_inst[14:12];
    assign w_f7    = i_inst[31:25];
    assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
    assign w_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign w_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_u = {i_inst[31:12], 12'b0};
    assign w_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    always_comb begin
        o_op = OP_NOP; o_rd = '0; o_rs1 = '0; o_rs2 = '0; o_imm = '0;
        o_is_jump = 1'b0; o_is_branch = 1'b0; o_is_load = 1'b0; o_is_store = 1'b0;
        case (w_opc)
            OPC_LUI:   begin o_op = OP_LUI;   o_rd = i_inst[11:7]; o_imm = w_imm_u; end
            OPC_AUIPC: begin o_op = OP_AUIPC; o_rd = i_inst[11:7]; o_imm = w_imm_u; end
            OPC_JAL:   begin o_op = OP_JAL;   o_rd = i_inst[11:7]; o_imm = w_imm_j; o_is_jump = 1'b1; end
            OPC_JALR: if (w_f3 == 3'd0) begin
                o_op = OP_JALR; o_rd = i_inst[11:7]; o_rs1 = i_inst[19:15];
                o_imm = w_imm_i; o_is_jump = 1'b1;
            end
            OPC_BRANCH: begin
                case (w_f3)
                    3'd0: o_op = OP_BEQ;  3'd1: o_op = OP_BNE;
                    3'd4: o_op = OP_BLT;  3'd5: o_op = OP_BGE;
                    3'd6: o_op = OP_BLTU; 3'd7: o_op = OP_BGEU;
                    default: o_op = OP_NOP;
                endcase
                // rd stays 0: branches write no register
                if (o_op != OP_NOP) begin
                    o_rs1 = i_inst[19:15]; o_rs2 = i_inst[24:20]; o_imm = w_imm_b; o_is_branch = 1'b1;
                end
            end
            OPC_LOAD: begin
                case (w_f3)
                    3'd0: o_op = OP_LB;  3'd1: o_op = OP_LH; 3'd2: o_op = OP_LW;
                    3'd4: o_op = OP_LBU; 3'd5: o_op = OP_LHU;
                    default: o_op = OP_NOP;
                endcase
                if (o_op != OP_NOP) begin
                    o_rd = i_inst[11:7]; o_rs1 = i_inst[19:15]; o_imm = w_imm_i; o_is_load = 1'b1;
                end
            end
            OPC_STORE: begin
                case (w_f3)
                    3'd0: o_op = OP_SB; 3'd1: o_op = OP_SH; 3'd2: o_op = OP_SW;
                    default: o_op = OP_NOP;
                endcase
                if (o_op != OP_NOP) begin
                    o_rs1 = i_inst[19:15]; o_rs2 = i_inst[24:20]; o_imm = w_imm_s; o_is_store = 1'b1;
                end
            end
            OPC_OPIMM: begin
                case (w_f3)
                    3'd0: o_op = OP_ADDI; 3'd2: o_op = OP_SLTI; 3'd3: o_op = OP_SLTIU;
                    3'd4: o_op = OP_XORI; 3'd6: o_op = OP_ORI;  3'd7: o_op = OP_ANDI;
                    3'd1: o_op = (w_f7 == F7_BASE) ? OP_SLLI : OP_NOP;
                    3'd5: o_op = (w_f7 == F7_BASE) ? OP_SRLI : ((w_f7 == F7_ALT) ? OP_SRAI : OP_NOP);
                    default: o_op = OP_NOP;
                endcase
                if (o_op != OP_NOP) begin
                    o_rd = i_inst[11:7]; o_rs1 = i_inst[19:15];
                    // shifts carry only the 5-bit shamt; funct7 is not part of the operand
                    o_imm = (w_f3 == 3'd1 || w_f3 == 3'd5) ? {27'b0, i_inst[24:20]} : w_imm_i;
                end
            end
            OPC_OP: begin
                case ({w_f7, w_f3})
                    {F7_BASE, 3'd0}: o_op = OP_ADD;  {F7_ALT, 3'd0}: o_op = OP_SUB;
                    {F7_BASE, 3'd1}: o_op = OP_SLL;  {F7_BASE, 3'd2}: o_op = OP_SLT;
                    {F7_BASE, 3'd3}: o_op = OP_SLTU; {F7_BASE, 3'd4}: o_op = OP_XOR;
                    {F7_BASE, 3'd5}: o_op = OP_SRL;  {F7_ALT, 3'd5}: o_op = OP_SRA;
                    {F7_BASE, 3'd6}: o_op = OP_OR;   {F7_BASE, 3'd7}: o_op = OP_AND;
                    default: o_op = OP_NOP;
                endcase
                if (o_op != OP_NOP) begin
                    o_rd = i_inst[11:7]; o_rs1 = i_inst[19:15]; o_rs2 = i_inst[24:20];
                end
            end
            default: o_op = OP_NOP;
        endcase
    end

endmodule

// File: rtl/inst_dispatcher.sv
// Instruction queue + single-issue dispatch to ROB and exactly one of RS/LSB.
// Latency: push on edge E dispatches earliest on edge E+1 (registered outputs, no bypass).
// Backpressure: head stalls on rob_full / rs_full / lsb_full; iq_full blocks fetch.
// Ports: clk/rst/rdy control; rollback flush; fetch_* push side with iq_full;
//        rob_full/rs_full/lsb_full/rob_free_tag backend status; disp_* registered dispatch bundle.
module inst_dispatcher
    import inst_dispatcher_pkg::*;
#(
    parameter int IQ_ADDR_W = IQ_ADDR_W_DEF,
    parameter int ROB_TAG_W = ROB_TAG_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic                 fetch_valid,
    input  logic [31:0]          fetch_inst,
    input  logic [31:0]          fetch_pc,
    input  logic                 fetch_pred_jump,
    output logic                 iq_full,
    input  logic                 rob_full,
    input  logic [ROB_TAG_W-1:0] rob_free_tag,
    input  logic                 rs_full,
    input  logic                 lsb_full,
    output logic                 disp_rob_valid,
    output logic                 disp_rs_valid,
    output logic                 disp_lsb_valid,
    output logic [5:0]           disp_op,
    output logic [4:0]           disp_rd,
    output logic [4:0]           disp_rs1,
    output logic [4:0]           disp_rs2,
    output logic [31:0]          disp_imm,
    output logic [31:0]          disp_pc,
    output logic                 disp_pred_jump,
    output logic                 disp_is_jump,
    output logic                 disp_is_branch,
    output logic [ROB_TAG_W-1:0] disp_tag
);
    localparam int DEPTH = 1 << IQ_ADDR_W;

    iq_entry_t              r_q [DEPTH];
    logic [IQ_ADDR_W-1:0]   r_head, r_tail;
    logic [IQ_ADDR_W:0]     r_count;
    state_e                 r_state, w_state_nxt;

    iq_entry_t              w_head;
    logic [5:0]             w_op;
    logic [4:0]             w_rd, w_rs1, w_rs2;
    logic [31:0]            w_imm;
    logic                   w_is_jump, w_is_branch, w_is_load, w_is_store;
    logic                   w_run, w_mem, w_nop, w_can_issue, w_push, w_pop;

    assign w_head = r_q[r_head];

    inst_dispatcher_decoder u_dec (
        .i_inst     (w_head.inst),
        .o_op       (w_op),
        .o_rd       (w_rd),
        .o_rs1      (w_rs1),
        .o_rs2      (w_rs2),
        .o_imm      (w_imm),
        .o_is_jump  (w_is_jump),
        .o_is_branch(w_is_branch),
        .o_is_load  (w_is_load),
        .o_is_store (w_is_store)
    );

    assign iq_full = (r_count == (IQ_ADDR_W + 1)'(DEPTH));

    // A rollback in the current cycle discards any push/dispatch alongside it
    assign w_run       = rdy && (r_state == ST_RUN) && !rollback;
    assign w_mem       = w_is_load | w_is_store;
    assign w_nop       = (w_op == OP_NOP);
    assign w_can_issue = w_mem ? !lsb_full : (w_nop || !rs_full);
    assign w_push      = w_run && fetch_valid && !iq_full;
    assign w_pop       = w_run && (r_count != '0) && !rob_full && w_can_issue;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   w_state_nxt = rollback ? ST_FLUSH : ST_RUN;
            ST_FLUSH: w_state_nxt = rollback ? ST_FLUSH : ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy) begin
            r_state <= w_state_nxt;
            if (rollback) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_tail <= r_tail + 1'b1;
                if (w_pop)  r_head <= r_head + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage needs no reset: an entry is only read after it has been written
    always_ff @(posedge clk) begin
        if (w_push) r_q[r_tail] <= '{inst: fetch_inst, pc: fetch_pc, pred_jump: fetch_pred_jump};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_rob_valid <= 1'b0; disp_rs_valid <= 1'b0; disp_lsb_valid <= 1'b0;
            disp_op <= '0; disp_rd <= '0; disp_rs1 <= '0; disp_rs2 <= '0;
            disp_imm <= '0; disp_pc <= '0; disp_pred_jump <= 1'b0;
            disp_is_jump <= 1'b0; disp_is_branch <= 1'b0; disp_tag <= '0;
        end else begin
            // w_pop already folds in rdy and rollback, so valids drop in those cases
            disp_rob_valid <= w_pop;
            disp_lsb_valid <= w_pop && w_mem;
            disp_rs_valid  <= w_pop && !w_mem && !w_nop;
            if (w_pop) begin
                disp_op        <= w_op;
                disp_rd        <= w_rd;
                disp_rs1       <= w_rs1;
                disp_rs2       <= w_rs2;
                disp_imm       <= w_imm;
                disp_pc        <= w_head.pc;
                disp_pred_jump <= w_head.pred_jump;
                disp_is_jump   <= w_is_jump;
                disp_is_branch <= w_is_branch;
                disp_tag       <= rob_free_tag;
            end
        end
    end

endmodule
